// File: rtl/batpu_pkg.sv
// rtl/batpu_pkg.sv - shared BatPU2 control-path types for the return-address stack
package batpu_pkg;

    localparam int PC_W = 10;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        STK_NOP  = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_REPL = 2'b11
    } stk_op_e;

    function automatic stk_op_e decode_stk_op(input logic push, input logic pop);
        case ({pop, push})
            2'b01:   return STK_PUSH;
            2'b10:   return STK_POP;
            2'b11:   return STK_REPL;
            default: return STK_NOP;
        endcase
    endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH register array, one sync write port, one async read port
module stack_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; count gating at the top hides stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - parametrised return-address stack with replace-top and sticky error flags
module return_addr_stack
    import batpu_pkg::*;
#(
    parameter int WIDTH = PC_W,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         top_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     err_ovf_o,
    output logic                     err_unf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr, ptr_nxt, top_ptr, waddr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             ovf, ovf_nxt, unf, unf_nxt;
    logic             we, empty, full;
    logic [WIDTH-1:0] rd_data;
    stk_op_e          op;

    assign op      = decode_stk_op(push_i, pop_i);
    assign top_ptr = ptr - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

    always_comb begin
        we        = 1'b0;
        waddr     = ptr;
        ptr_nxt   = ptr;
        count_nxt = count;
        ovf_nxt   = ovf;
        unf_nxt   = unf;
        if (clear_i) begin
            ptr_nxt   = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
        end else begin
            case (op)
                STK_PUSH: begin
                    if (!full) begin
                        we        = 1'b1;
                        ptr_nxt   = ptr + PTR_W'(1);
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                        // Circular mode: the write slot is also the oldest entry.
                        if (WRAP != 0) begin
                            we      = 1'b1;
                            ptr_nxt = ptr + PTR_W'(1);
                        end
                    end
                end
                STK_POP: begin
                    if (!empty) begin
                        ptr_nxt   = top_ptr;
                        count_nxt = count - CNT_W'(1);
                    end else begin
                        unf_nxt = 1'b1;
                    end
                end
                STK_REPL: begin
                    we = 1'b1;
                    if (empty) begin
                        ptr_nxt   = ptr + PTR_W'(1);
                        count_nxt = CNT_W'(1);
                    end else begin
                        waddr = top_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din_i),
        .raddr (top_ptr),
        .rdata (rd_data)
    );

    assign top_o     = empty ? '0 : rd_data;
    assign count_o   = count;
    assign empty_o   = empty;
    assign full_o    = full;
    assign err_ovf_o = ovf;
    assign err_unf_o = unf;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - directed self-checking bench, drop (WRAP=0) and circular (WRAP=1) instances
module tb_return_addr_stack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push, pop, clr;
    logic [9:0] din;

    logic [9:0] top0, top1;
    logic [4:0] cnt0, cnt1;
    logic       emp0, emp1, full0, full1, ovf0, ovf1, unf0, unf1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    return_addr_stack #(.WIDTH(10), .DEPTH(16), .WRAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .clear_i(clr), .din_i(din),
        .top_o(top0), .count_o(cnt0), .empty_o(emp0), .full_o(full0),
        .err_ovf_o(ovf0), .err_unf_o(unf0)
    );

    return_addr_stack #(.WIDTH(10), .DEPTH(16), .WRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .clear_i(clr), .din_i(din),
        .top_o(top1), .count_o(cnt1), .empty_o(emp1), .full_o(full1),
        .err_ovf_o(ovf1), .err_unf_o(unf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clocked operation; returns #1 after the edge so outputs are settled.
    task automatic drive(input logic p, input logic q, input logic c, input logic [9:0] d);
        push = p; pop = q; clr = c; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", cnt0, 0);
        check("rst_empty", emp0, 1);
        check("rst_full",  full0, 0);
        check("rst_top",   top0, 0);
        check("rst_errs",  {ovf0, unf0}, 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 16; i++) drive(1, 0, 0, 10'(i));
        check("fill_full0", full0, 1);
        check("fill_top0",  top0, 10'h010);
        check("fill_cnt0",  cnt0, 16);
        check("fill_ovf0",  ovf0, 0);
        check("fill_full1", full1, 1);

        drive(1, 0, 0, 10'h3FF);
        check("ovf_flag0", ovf0, 1);
        check("ovf_top0",  top0, 10'h010);
        check("ovf_cnt0",  cnt0, 16);
        check("ovf_flag1", ovf1, 1);
        check("ovf_top1",  top1, 10'h3FF);
        check("ovf_cnt1",  cnt1, 16);

        for (int i = 0; i < 16; i++) begin
            check("pop_top0", top0, 16 - i);
            check("pop_top1", top1, (i == 0) ? 32'h3FF : 32'(17 - i));
            drive(0, 1, 0, '0);
        end
        check("drain_empty0", emp0, 1);
        check("drain_empty1", emp1, 1);
        check("drain_top0",   top0, 0);
        check("drain_unf0",   unf0, 0);

        drive(0, 1, 0, '0);
        check("unf_flag", unf0, 1);
        check("unf_cnt",  cnt0, 0);
        drive(0, 0, 1, '0);
        check("clr_unf", unf0, 0);
        check("clr_ovf", ovf0, 0);

        drive(1, 0, 0, 10'h005);
        drive(1, 0, 0, 10'h007);
        drive(1, 1, 0, 10'h123);
        check("repl_cnt", cnt0, 2);
        check("repl_top", top0, 10'h123);
        check("repl_err", {ovf0, unf0}, 0);
        drive(0, 1, 0, '0);
        check("repl_pop_top", top0, 10'h005);
        check("repl_pop_cnt", cnt0, 1);

        drive(0, 0, 1, '0);
        drive(1, 1, 0, 10'h042);
        check("pp_empty_cnt", cnt0, 1);
        check("pp_empty_top", top0, 10'h042);
        check("pp_empty_unf", unf0, 0);
        drive(1, 0, 1, 10'h0AA);
        check("clr_push_cnt",   cnt0, 0);
        check("clr_push_empty", emp0, 1);

        drive(0, 1, 0, '0);
        drive(1, 0, 0, 10'h055);
        check("pre_arst_cnt", cnt0, 1);
        check("pre_arst_unf", unf0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt",   cnt0, 0);
        check("arst_empty", emp0, 1);
        check("arst_top",   top0, 0);
        check("arst_errs",  {ovf0, unf0}, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_cnt", cnt0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
